if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
// - Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the synchronous inst SRAM,
//   produces if_to_id_bus and consumes br_bus from the decode stage.
// - Holds the fetched instruction stable while decode is stalled, so decode needs no is_stop hack.
// - Latches a redirect that arrives while fetch is stalled, so the branch is never lost.
// PARAMETERS
// - RESET_PC   32'hBFC0_0000  first fetched address after reset
// PORTS
// - clk             in   1    clock
// - rst             in   1    reset rst, synchronous, active-high
// - stall           in   6    `StallBus; stall[0]=PC/IF, stall[1]=ID, stall[2]=EX; `Stop=1
// - flush           in   1    exception flush; redirect to new_pc
// - new_pc          in   32   flush target
// - br_bus          in   33   {br_e, br_addr} from decode
// - inst_sram_rdata in   32   SRAM data; valid one cycle after the address is issued
// - inst_sram_en    out  1    fetch enable
// - inst_sram_wen   out  4    always 4'b0
// - inst_sram_addr  out  32   = pc_reg
// - inst_sram_wdata out  32   always 32'b0
// - if_to_id_bus    out  33   {ce_reg, pc_reg}
// - id_inst         out  32   instruction aligned with the PC that decode holds
// - if_adel         out  1    fetch address error (see CONFIGURATION)
// BEHAVIOUR
// - Reset: pc_reg=RESET_PC-4 (BFBF_FFFC), ce_reg=0, br_pend=0, hold_valid=0, inst_sram_en=0, if_adel=0.
// - next_pc priority: flush -> new_pc; br_e -> br_addr; br_pend -> pend_addr; else pc_reg+4.
//   Adds wrap modulo 2^32.
// - Register update at posedge:
//   - flush: pc_reg<=new_pc, ce_reg<=1, br_pend<=0. A flush is never blocked by stall.
//   - Otherwise, stall[0]==`NoStop: pc_reg<=next_pc, ce_reg<=1, br_pend<=0.
//   - Otherwise, stall[0]==`Stop: pc_reg and ce_reg hold.
//     - If br_e and stall[1]==`NoStop: br_pend<=1, pend_addr<=br_addr.
//     - br_e while stall[1]==`Stop is ignored; decode re-evaluates the branch after the stall.
// - inst_sram_en = ce_reg; inst_sram_addr = pc_reg. Fetch latency is 1 cycle from address to data.
// - Hold buffer:
//   - First cycle with stall[1]==`Stop and hold_valid==0: hold_q<=inst_sram_rdata, hold_valid<=1.
//   - Cleared when stall[1]==`NoStop, on flush, or on rst.
//   - id_inst = hold_valid ? hold_q : inst_sram_rdata.
// - Branch delay slot: the instruction already in IF when br_e is seen is still delivered; only the
//   following PC is redirected.
// - Reset mid-stall clears br_pend and hold_valid; no stale redirect survives.
// CONFIGURATION
// - IF_FETCH_ALIGN_CHECK_EN defined:
//   - if_adel = ce_reg & (pc_reg[1:0]!=0).
//   - While if_adel is 1, inst_sram_en is forced to 0 and the PC keeps its normal next_pc flow; the
//     exception unit flushes.
// - Undefined: if_adel tied 0; no alignment logic.
// STRUCTURE
// - lib/defines.vh holds IF_TO_ID_WD(33), BR_WD(33), StallBus(6), Stop/NoStop and RESET_PC_DEFAULT.
// - One sub-module, inst_hold_buf: hold_q/hold_valid register plus the id_inst mux.
// TESTING
// - Reset held 2 cycles -> addr=BFBF_FFFC, en=0. First cycle after release -> addr=BFC0_0000, en=1.
// - No stall for 3 cycles -> addr sequence BFC0_0000, BFC0_0004, BFC0_0008.
// - br_bus={1,BFC0_0100} while addr=BFC0_0004 -> next addr=BFC0_0100.
// - stall=6'b000001 with br_bus={1,BFC0_0200} -> addr holds and br_pend=1; release with br_e=0
//   -> addr=BFC0_0200 and br_pend=0.
// - stall=6'b000011 for 3 cycles while rdata steps 2401_0001 -> DEAD_BEEF -> 0 -> id_inst stays
//   2401_0001; after release id_inst follows rdata.
// - flush, new_pc=BFC0_0380, br_e=1 to BFC0_0100 and stall=6'b000111 in the same cycle
//   -> addr=BFC0_0380, br_pend=0, hold_valid=0.
// - (macro) jr target BFC0_0102 -> if_adel=1 and en=0 for that cycle.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_pkg
// Brief   : Shared widths, stall encoding and bus types for the IF stage.
// Revision: 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

   localparam int IF_TO_ID_WD  = 33;
   localparam int BR_WD        = 33;
   localparam int STALL_BUS_WD = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

   typedef struct packed {
      logic        br_e;
      logic [31:0] br_addr;
   } br_bus_t;

   typedef struct packed {
      logic        ce;
      logic [31:0] pc;
   } if_to_id_t;

endpackage : if_fetch_unit_pkg
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_if
// Brief   : Synchronous instruction SRAM port between fetch and memory.
// Revision: 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if;

   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output en,
      output wen,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  en,
      input  wen,
      input  addr,
      input  wdata,
      output rdata
   );

endinterface : if_fetch_unit_if
`default_nettype wire

// File: rtl/if_fetch_unit_inst_hold_buf.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_inst_hold_buf
// Brief   : Captures the SRAM word on the first decode-stall cycle and replays it.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit_inst_hold_buf
   import if_fetch_unit_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        flush,
   input  wire logic        id_stall,
   input  wire logic [31:0] rdata,
   output logic [31:0]      id_inst
);

   logic [31:0] hold_q;
   logic        hold_valid;

   always_ff @(posedge clk) begin
      if (rst || flush || (id_stall == NO_STOP)) begin
         hold_valid <= 1'b0;
      end else if (!hold_valid) begin
         hold_q     <= rdata;
         hold_valid <= 1'b1;
      end
   end

   assign id_inst = hold_valid ? hold_q : rdata;

endmodule : if_fetch_unit_inst_hold_buf
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit
// Brief   : IF stage: PC, inst SRAM drive, pending-redirect latch, decode hold.
//           Optional IF_FETCH_ALIGN_CHECK_EN adds the fetch address-error check.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic [STALL_BUS_WD-1:0] stall,
   input  wire logic                    flush,
   input  wire logic [31:0]             new_pc,
   input  wire logic [BR_WD-1:0]        br_bus,
   if_fetch_unit_if.master              inst_sram,
   output logic [IF_TO_ID_WD-1:0]       if_to_id_bus,
   output logic [31:0]                  id_inst,
   output logic                         if_adel
);

   localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

   br_bus_t     br;
   logic [31:0] pc_reg;
   logic        ce_reg;
   logic        br_pend;
   logic [31:0] pend_addr;
   logic [31:0] next_pc;
   logic        unused_stall;

   assign br           = br_bus_t'(br_bus);
   assign unused_stall = ^stall[STALL_BUS_WD-1:2];

   always_comb begin
      next_pc = pc_reg + 32'd4;
      if (flush)          next_pc = new_pc;
      else if (br.br_e)   next_pc = br.br_addr;
      else if (br_pend)   next_pc = pend_addr;
   end

   // A branch seen while only IF is frozen must survive until the PC can move.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= PC_RESET_VAL;
         ce_reg    <= 1'b0;
         br_pend   <= 1'b0;
         pend_addr <= 32'd0;
      end else if (flush || (stall[0] == NO_STOP)) begin
         pc_reg  <= next_pc;
         ce_reg  <= 1'b1;
         br_pend <= 1'b0;
      end else if (br.br_e && (stall[1] == NO_STOP)) begin
         br_pend   <= 1'b1;
         pend_addr <= br.br_addr;
      end
   end

`ifdef IF_FETCH_ALIGN_CHECK_EN
   assign if_adel      = ce_reg & (pc_reg[1:0] != 2'b00);
   assign inst_sram.en = ce_reg & ~if_adel;
`else
   assign if_adel      = 1'b0;
   assign inst_sram.en = ce_reg;
`endif

   assign inst_sram.wen   = 4'b0000;
   assign inst_sram.addr  = pc_reg;
   assign inst_sram.wdata = 32'd0;
   assign if_to_id_bus    = {ce_reg, pc_reg};

   if_fetch_unit_inst_hold_buf u_hold_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .id_stall (stall[1]),
      .rdata    (inst_sram.rdata),
      .id_inst  (id_inst)
   );

endmodule : if_fetch_unit
`default_nettype wire
